bht_update_queue: RTL and testbench
===================================

// Module: bht_update_queue
// PURPOSE
// Buffers resolved-branch updates from execute and replays them, one per accepted handshake, into the BHT update port.
// Execute cannot stall, so the queue absorbs bursts while the BHT write port is busy with frontend lookups.
// Updates to the same PC as the youngest queued entry are coalesced in place.
// Sits between the execute-stage branch unit and the bht update input.
// PARAMETERS
// CVA6Cfg       config_pkg::cva6_cfg_empty  CVA6 config; only CVA6Cfg.VLEN is used (pc width)
// bht_update_t  logic                       struct {valid; pc[VLEN-1:0]; taken}
// DEPTH         4                           entries; power of two, >=2
// DROP_CNT_W    16                          width of the saturating drop counter
// PORTS
// clk_i           in   1             clock, rising edge
// rst_i           in   1             synchronous reset, active-high
// flush_i         in   1             discard all queued entries (e.g. debug or fence.i)
// bht_update_i    in   bht_update_t  resolved branch from execute; push when .valid
// bht_update_o    out  bht_update_t  head entry; .valid = queue non-empty
// bht_ready_i     in   1             BHT accepts bht_update_o this cycle
// full_o          out  1             count == DEPTH
// drop_cnt_o      out  DROP_CNT_W    number of updates lost to overflow; saturates
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): head=tail=count=0, drop_cnt_o=0, bht_update_o.valid=0, full_o=0; payload contents don't care.
// - Pop: bht_update_o.valid & bht_ready_i -> head++ (mod DEPTH), count--.
// - Push: bht_update_i.valid -> write at tail, tail++, count++.
// - Latency: push at edge N, visible on bht_update_o from cycle N+1. There is no combinational bypass.
// - Coalesce: if count>0 & bht_update_i.valid & pc == youngest entry pc, and the youngest entry is not being popped this cycle:
//   - overwrite that entry's taken in place;
//   - no pointer or count change.
// - If the youngest entry is the head and is popped this cycle, treat the input as a normal push.
// - Full & push & no pop & no coalesce:
//   - drop the incoming update;
//   - drop_cnt_o++, saturating at all-ones.
// - Full & push & pop in the same cycle: accept both; count stays DEPTH.
// - Empty & push & bht_ready_i: no pop, since valid was 0; the entry appears the next cycle.
// - Pointers wrap modulo DEPTH and carry one extra bit to tell full from empty; full_o = (count == DEPTH).
// - flush_i: head=tail=count=0 next cycle.
//   - A push in the same cycle is discarded and not counted as a drop.
//   - An in-flight pop handshake that cycle still completes (the BHT has sampled it).
//   - drop_cnt_o is preserved.
// - rst_i wins over flush_i and all other inputs.
// - bht_update_o is driven from registers only: no combinational path from bht_update_i.
// - Assertions: count <= DEPTH; bht_update_o.valid == (count != 0).
// STRUCTURE
// - bht_update_t comes from the shared core package alongside the other branch-predictor typedefs.
// - ptr_t = logic[$clog2(DEPTH):0] and cnt_t are local typedefs.
// - Add the constant BHT_UPDQ_DEPTH_DEFAULT=4 to that same package so the frontend and the bench agree.
// - One natural sub-module, bht_update_queue_mem: DEPTH x bht_update_t register array.
//   - 1 write port (push or coalesce), 1 async read at head, 1 async read at tail-1 for the coalesce compare.
// - Pointer, count and drop logic stay in the top level.
// TESTING
// 1. Reset: hold rst_i 2 cycles mid-traffic with count=3 -> next cycle valid=0, full_o=0, drop_cnt_o=0.
// 2. Ordering: push pc 0x1000 T, 0x1004 NT, 0x1008 T with ready=1 -> outputs appear one per cycle in the same order, each 1 cycle after its push.
// 3. Coalesce: ready=0; push 0x2000 T then 0x2000 NT -> count=1, head taken=0.
//    Then push 0x2004 and 0x2000 -> count=3, no coalesce.
// 4. Overflow: ready=0, DEPTH=4; push 6 distinct pcs -> full_o=1, drop_cnt_o=2, first 4 entries intact.
//    Then full + push + ready=1 -> accepted, count stays 4.
// 5. Saturation: DROP_CNT_W=2; 5 overflow drops -> drop_cnt_o=3.
// 6. Flush: count=3, flush_i=1 with simultaneous push and ready=1 -> popped entry observed once, next cycle valid=0, drop_cnt_o unchanged.
//    Then wrap: random push/ready for 10k cycles vs a scoreboard model, with tail wrapping >100 times.

Source files
------------

// File: rtl/bht_update_queue_pkg.sv
// -----------------------------------------------------------------------------
// bht_update_queue_pkg
// Shared branch-predictor types and constants for the BHT update queue.
//
// Contents
//   VLEN                    virtual address width (branch PC width)
//   BHT_UPDQ_DEPTH_DEFAULT  default queue depth, shared by frontend and bench
//   bht_update_t            resolved-branch update {valid, pc, taken}
//   bhtq_entry_t            stored queue payload {pc, taken} (valid is implied
//                           by the occupancy count, so it is not stored)
//   is_pow2()               elaboration-time helper for depth checking
// -----------------------------------------------------------------------------
package bht_update_queue_pkg;

    localparam int unsigned VLEN                   = 64;
    localparam int unsigned BHT_UPDQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } bhtq_entry_t;

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bht_update_queue_if.sv
// -----------------------------------------------------------------------------
// bht_update_queue_if
// Groups the execute-side push, the BHT-side pop handshake and the queue
// status into one bundle.
//
// Signals
//   flush_i       discard every queued entry
//   bht_update_i  resolved branch from execute; pushed when .valid
//   bht_update_o  head entry; .valid means the queue is non-empty
//   bht_ready_i   BHT accepts bht_update_o this cycle
//   full_o        queue holds DEPTH entries
//   drop_cnt_o    saturating count of updates lost to overflow
//
// Modports
//   slave   the queue itself
//   master  the surrounding pipeline (execute + BHT), or a testbench
// -----------------------------------------------------------------------------
interface bht_update_queue_if
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = 16
) ();

    logic                  flush_i;
    bht_update_t           bht_update_i;
    bht_update_t           bht_update_o;
    logic                  bht_ready_i;
    logic                  full_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o;

    modport slave (
        input  flush_i,
        input  bht_update_i,
        input  bht_ready_i,
        output bht_update_o,
        output full_o,
        output drop_cnt_o
    );

    modport master (
        output flush_i,
        output bht_update_i,
        output bht_ready_i,
        input  bht_update_o,
        input  full_o,
        input  drop_cnt_o
    );

endinterface

// File: rtl/bht_update_queue_mem.sv
// -----------------------------------------------------------------------------
// bht_update_queue_mem
// DEPTH x bhtq_entry_t register array backing the update queue.
//
// Ports
//   clk_i      clock, rising edge
//   we         write enable (push at tail, or coalesce into youngest entry)
//   waddr      write index
//   wdata      entry to write
//   head_addr  index of the oldest entry
//   head_data  asynchronous read of the oldest entry (drives the BHT port)
//   tail_addr  index of the youngest entry (tail - 1)
//   tail_pc    asynchronous read of the youngest entry's PC, for coalescing
// -----------------------------------------------------------------------------
module bht_update_queue_mem
    import bht_update_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = BHT_UPDQ_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  bhtq_entry_t     wdata,
    input  logic [AW-1:0]   head_addr,
    output bhtq_entry_t     head_data,
    input  logic [AW-1:0]   tail_addr,
    output logic [VLEN-1:0] tail_pc
);

    bhtq_entry_t mem [DEPTH];

    // NOTE: the payload array has no reset. Occupancy is tracked by the
    // pointers and count, so stale contents are never observed as valid and
    // the array can map onto plain flops or a small RAM without reset wiring.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign head_data = mem[head_addr];
    assign tail_pc   = mem[tail_addr].pc;

endmodule

// File: rtl/bht_update_queue.sv
// -----------------------------------------------------------------------------
// bht_update_queue
// Buffers resolved-branch updates from execute and replays them, one per
// accepted handshake, into the BHT update port. Execute cannot stall, so the
// queue absorbs bursts while the BHT write port is busy; a new update to the
// same PC as the youngest queued entry overwrites that entry's direction in
// place instead of consuming a slot. Overflowing updates are dropped and
// counted in a saturating counter.
//
// Ports
//   clk_i  clock, rising edge
//   rst_i  synchronous reset, active-high; wins over every other input
//   bus    bht_update_queue_if.slave (flush, push, pop handshake, status)
//
// Parameters
//   DEPTH       number of entries; power of two, >= 2
//   DROP_CNT_W  width of the saturating drop counter
//
// Timing
//   An update pushed at edge N is visible on bht_update_o from cycle N+1.
//   bht_update_o is driven from state only; there is no bypass from the input.
// -----------------------------------------------------------------------------
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = BHT_UPDQ_DEPTH_DEFAULT,
    parameter int unsigned DROP_CNT_W = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    bht_update_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one bit beyond the index so full and empty differ.
    typedef logic [AW:0]           ptr_t;
    typedef logic [AW:0]           cnt_t;
    typedef logic [AW-1:0]         idx_t;
    typedef logic [DROP_CNT_W-1:0] drop_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("bht_update_queue: DEPTH must be a power of two and at least 2");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    ptr_t  head_q;
    ptr_t  tail_q;
    cnt_t  count_q;
    drop_t drop_cnt_q;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    idx_t            head_idx;
    idx_t            tail_idx;
    idx_t            young_idx;
    bhtq_entry_t     head_entry;
    logic [VLEN-1:0] young_pc;
    logic            mem_we;
    idx_t            mem_waddr;
    bhtq_entry_t     mem_wdata;

    assign head_idx  = head_q[AW-1:0];
    assign tail_idx  = tail_q[AW-1:0];
    assign young_idx = tail_idx - idx_t'(1);

    bht_update_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .head_addr (head_idx),
        .head_data (head_entry),
        .tail_addr (young_idx),
        .tail_pc   (young_pc)
    );

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic not_empty;
    logic full;
    logic pop;
    logic push_req;
    logic young_popped;
    logic coalesce;
    logic push;
    logic drop;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = not_empty & bus.bht_ready_i;
    assign push_req  = bus.bht_update_i.valid;

    // The youngest entry leaves this cycle only when it is also the head.
    // In that case the incoming update must become a fresh entry, otherwise
    // its direction would be lost with the popped slot.
    assign young_popped = pop & (count_q == cnt_t'(1));
    assign coalesce     = push_req & not_empty & ~young_popped &
                          (young_pc == bus.bht_update_i.pc);

    // A full queue still takes a push when a slot frees up the same cycle.
    assign push = push_req & ~coalesce & (~full | pop);
    assign drop = push_req & ~coalesce & full & ~pop;

    // Write port: coalesce rewrites the youngest slot (same PC, new taken),
    // a push fills the slot at tail. A flushed push never lands.
    // NOTE: every signal written in this always_comb gets a default first, so
    // no path through the block leaves a value held and no latch is inferred.
    always_comb begin
        mem_we          = 1'b0;
        mem_waddr       = tail_idx;
        mem_wdata.pc    = bus.bht_update_i.pc;
        mem_wdata.taken = bus.bht_update_i.taken;
        if (!bus.flush_i) begin
            if (coalesce) begin
                mem_we    = 1'b1;
                mem_waddr = young_idx;
            end else if (push) begin
                mem_we    = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy and drop counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement
    // order; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else if (bus.flush_i) begin
            // Any pop this cycle was already sampled by the BHT; the push is
            // discarded and is not an overflow, so drop_cnt_q is untouched.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                head_q <= head_q + ptr_t'(1);
            end
            if (push) begin
                tail_q <= tail_q + ptr_t'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + drop_t'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (state only: count, head pointer and the storage array)
    // -------------------------------------------------------------------------
    assign bus.bht_update_o = '{valid: not_empty,
                                pc:    head_entry.pc,
                                taken: head_entry.taken};
    assign bus.full_o       = full;
    assign bus.drop_cnt_o   = drop_cnt_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_count_bound : assert property (
        @(posedge clk_i) disable iff (rst_i)
        count_q <= FULL_CNT
    );

    a_valid_matches_count : assert property (
        @(posedge clk_i) disable iff (rst_i)
        bus.bht_update_o.valid == (count_q != '0)
    );

    a_ptr_count_consistent : assert property (
        @(posedge clk_i) disable iff (rst_i)
        ptr_t'(tail_q - head_q) == count_q
    );

    a_no_push_and_drop : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(push && drop) && !(coalesce && (push || drop))
    );

endmodule

// File: tb/tb_bht_update_queue.sv
// -----------------------------------------------------------------------------
// tb_bht_update_queue
// Directed table of per-cycle vectors with hand-computed expectations, hand
// sequences for reset, flush-while-full and post-reset latency, then a long
// random run against a queue model. A second instance with a 2-bit drop
// counter sees the same stimulus to cover saturation.
// -----------------------------------------------------------------------------
module tb_bht_update_queue;
    import bht_update_queue_pkg::*;

    localparam int unsigned DEPTH = BHT_UPDQ_DEPTH_DEFAULT;

    logic clk = 1'b0;
    logic rst_i;

    always #5 clk = ~clk;

    bht_update_queue_if #(.DROP_CNT_W(16)) bus     ();
    bht_update_queue_if #(.DROP_CNT_W(2))  bus_sat ();

    bht_update_queue #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    bht_update_queue #(.DEPTH(DEPTH), .DROP_CNT_W(2)) dut_sat (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus_sat)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        flush;
        logic        in_v;
        logic [63:0] pc;
        logic        taken;
        logic        ready;
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_taken;
        logic        e_full;
        logic [15:0] e_drop;
        logic [1:0]  e_sat;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic flush, input logic v, input logic [63:0] pc,
                         input logic taken, input logic ready);
        bus.flush_i          = flush;
        bus.bht_update_i     = '{valid: v, pc: pc, taken: taken};
        bus.bht_ready_i      = ready;
        bus_sat.flush_i      = flush;
        bus_sat.bht_update_i = '{valid: v, pc: pc, taken: taken};
        bus_sat.bht_ready_i  = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [63:0] epc,
                             input logic et, input logic ef, input logic [15:0] ed,
                             input logic [1:0] es);
        check({tag, " valid"}, 64'(bus.bht_update_o.valid), 64'(ev));
        if (ev) begin
            check({tag, " pc"},    bus.bht_update_o.pc,          epc);
            check({tag, " taken"}, 64'(bus.bht_update_o.taken),  64'(et));
        end
        check({tag, " full"},     64'(bus.full_o),          64'(ef));
        check({tag, " drop"},     64'(bus.drop_cnt_o),      64'(ed));
        check({tag, " drop_sat"}, 64'(bus_sat.drop_cnt_o),  64'(es));
    endtask

    function automatic vec_t mk(input logic fl, input logic v, input logic [63:0] pc,
                                input logic tk, input logic rd, input logic ev,
                                input logic [63:0] epc, input logic et, input logic ef,
                                input logic [15:0] ed, input logic [1:0] es);
        vec_t r;
        r.flush = fl; r.in_v = v; r.pc = pc; r.taken = tk; r.ready = rd;
        r.e_valid = ev; r.e_pc = epc; r.e_taken = et; r.e_full = ef;
        r.e_drop = ed; r.e_sat = es;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        // Ordering, one entry per cycle with ready=1
        tbl.push_back(mk(0,1,64'h1000,1,1, 1,64'h1000,1,0,0,0));
        tbl.push_back(mk(0,1,64'h1004,0,1, 1,64'h1004,0,0,0,0));
        tbl.push_back(mk(0,1,64'h1008,1,1, 1,64'h1008,1,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,    0,64'h0,0,0,0,0));
        // Same PC as a youngest entry that is popped this cycle: normal push
        tbl.push_back(mk(0,1,64'h3000,1,0, 1,64'h3000,1,0,0,0));
        tbl.push_back(mk(0,1,64'h3000,0,1, 1,64'h3000,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,    0,64'h0,0,0,0,0));
        // Coalesce, then non-youngest PC match
        tbl.push_back(mk(0,1,64'h2000,1,0, 1,64'h2000,1,0,0,0));
        tbl.push_back(mk(0,1,64'h2000,0,0, 1,64'h2000,0,0,0,0));
        tbl.push_back(mk(0,1,64'h2004,1,0, 1,64'h2000,0,0,0,0));
        tbl.push_back(mk(0,1,64'h2000,1,0, 1,64'h2000,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,    1,64'h2004,1,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,    1,64'h2000,1,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,1,    0,64'h0,0,0,0,0));
        // Overflow: six distinct pushes into four slots
        tbl.push_back(mk(0,1,64'h4000,1,0, 1,64'h4000,1,0,0,0));
        tbl.push_back(mk(0,1,64'h4004,0,0, 1,64'h4000,1,0,0,0));
        tbl.push_back(mk(0,1,64'h4008,1,0, 1,64'h4000,1,0,0,0));
        tbl.push_back(mk(0,1,64'h400C,0,0, 1,64'h4000,1,1,0,0));
        tbl.push_back(mk(0,1,64'h4010,1,0, 1,64'h4000,1,1,1,1));
        tbl.push_back(mk(0,1,64'h4014,1,0, 1,64'h4000,1,1,2,2));
        // Coalesce while full is not a drop
        tbl.push_back(mk(0,1,64'h400C,1,0, 1,64'h4000,1,1,2,2));
        // Full + push + pop: both accepted, still full
        tbl.push_back(mk(0,1,64'h4018,1,1, 1,64'h4004,0,1,2,2));
        tbl.push_back(mk(0,0,64'h0,0,1,    1,64'h4008,1,0,2,2));
        tbl.push_back(mk(0,0,64'h0,0,1,    1,64'h400C,1,0,2,2));
        tbl.push_back(mk(0,0,64'h0,0,1,    1,64'h4018,1,0,2,2));
        tbl.push_back(mk(0,0,64'h0,0,1,    0,64'h0,0,0,2,2));
        // More drops: 16-bit counter reaches 5, 2-bit counter saturates at 3
        tbl.push_back(mk(0,1,64'h5000,1,0, 1,64'h5000,1,0,2,2));
        tbl.push_back(mk(0,1,64'h5004,0,0, 1,64'h5000,1,0,2,2));
        tbl.push_back(mk(0,1,64'h5008,1,0, 1,64'h5000,1,0,2,2));
        tbl.push_back(mk(0,1,64'h500C,0,0, 1,64'h5000,1,1,2,2));
        tbl.push_back(mk(0,1,64'h5010,1,0, 1,64'h5000,1,1,3,3));
        tbl.push_back(mk(0,1,64'h5014,0,0, 1,64'h5000,1,1,4,3));
        tbl.push_back(mk(0,1,64'h5018,1,0, 1,64'h5000,1,1,5,3));
        // Pop to count=3, then flush with push and a completing pop
        tbl.push_back(mk(0,0,64'h0,0,1,    1,64'h5004,0,0,5,3));
        tbl.push_back(mk(1,1,64'h6000,1,1, 0,64'h0,0,0,5,3));
        tbl.push_back(mk(0,0,64'h0,0,0,    0,64'h0,0,0,5,3));

        // Reset
        rst_i = 1'b1;
        drive(0, 0, 64'h0, 0, 0);
        tick();
        tick();
        check_out("reset", 0, 64'h0, 0, 0, 16'd0, 2'd0);
        rst_i = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].flush, tbl[i].in_v, tbl[i].pc, tbl[i].taken, tbl[i].ready);
            tick();
            check_out($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_taken,
                      tbl[i].e_full, tbl[i].e_drop, tbl[i].e_sat);
        end

        // Reset mid-traffic with three entries queued
        drive(0, 1, 64'h7000, 1, 0); tick();
        check_out("mid_fill0", 1, 64'h7000, 1, 0, 16'd5, 2'd3);
        drive(0, 1, 64'h7004, 0, 0); tick();
        drive(0, 1, 64'h7008, 1, 0); tick();
        rst_i = 1'b1;
        drive(0, 1, 64'h700C, 0, 1);
        tick();
        tick();
        rst_i = 1'b0;
        drive(0, 0, 64'h0, 0, 0);
        check_out("mid_reset", 0, 64'h0, 0, 0, 16'd0, 2'd0);
        tick();
        check_out("post_reset_idle", 0, 64'h0, 0, 0, 16'd0, 2'd0);
        drive(0, 1, 64'h7100, 0, 0); tick();
        check_out("post_reset_push", 1, 64'h7100, 0, 0, 16'd0, 2'd0);
        drive(0, 0, 64'h0, 0, 1); tick();
        check_out("post_reset_drain", 0, 64'h0, 0, 0, 16'd0, 2'd0);

        // Flush while full: the discarded push is not an overflow
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 64'h7200 + 64'(4 * i), 1, 0);
            tick();
        end
        check_out("fill_full", 1, 64'h7200, 1, 1, 16'd0, 2'd0);
        drive(1, 1, 64'h7300, 1, 0); tick();
        check_out("flush_full", 0, 64'h0, 0, 0, 16'd0, 2'd0);
        drive(0, 0, 64'h0, 0, 0); tick();
        check_out("flush_after", 0, 64'h0, 0, 0, 16'd0, 2'd0);
        drive(0, 1, 64'h7400, 1, 0); tick();
        check_out("flush_repush", 1, 64'h7400, 1, 0, 16'd0, 2'd0);
        drive(1, 0, 64'h0, 0, 0); tick();
        check_out("flush_clear", 0, 64'h0, 0, 0, 16'd0, 2'd0);

        // Random traffic against a queue model
        begin
            int unsigned m_drop   = 0;
            int unsigned n_pushes = 0;
            for (int c = 0; c < 10000; c++) begin
                logic        fl, v, tk, rd, pop, coal;
                logic [63:0] pc;
                int          sz;
                fl = ($urandom_range(0, 199) == 0);
                v  = ($urandom_range(0, 99) < 55);
                rd = ($urandom_range(0, 99) < 50);
                tk = 1'($urandom_range(0, 1));
                pc = 64'h8000 + 64'($urandom_range(0, 3) * 4);
                sz = q.size();
                pop = (sz > 0) && rd;
                if (fl) begin
                    q.delete();
                end else begin
                    coal = v && (sz > 0) && (q[sz-1].pc == pc) && !(pop && sz == 1);
                    if (pop) void'(q.pop_front());
                    if (v) begin
                        if (coal) q[q.size()-1].taken = tk;
                        else if (q.size() < DEPTH) begin
                            q.push_back('{pc: pc, taken: tk});
                            n_pushes++;
                        end else m_drop++;
                    end
                end
                drive(fl, v, pc, tk, rd);
                tick();
                check($sformatf("rnd%0d valid", c), 64'(bus.bht_update_o.valid), 64'(q.size() != 0));
                if (q.size() != 0) begin
                    check($sformatf("rnd%0d pc", c), bus.bht_update_o.pc, q[0].pc);
                    check($sformatf("rnd%0d taken", c), 64'(bus.bht_update_o.taken), 64'(q[0].taken));
                end
                check($sformatf("rnd%0d full", c), 64'(bus.full_o), 64'(q.size() == DEPTH));
                check($sformatf("rnd%0d drop", c), 64'(bus.drop_cnt_o), 64'(m_drop));
            end
            if (n_pushes < 400)
                $display("note: only %0d accepted pushes in random phase", n_pushes);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
